// File: rtl/range_stats_unit.sv
// Running min/max/range/count over a go/finish framed sample sequence.
// Optional running sum output is enabled by defining RANGE_STATS_SUM_EN.
module range_stats_unit #(
    parameter int WIDTH       = 8,
    parameter int COUNT_WIDTH = 8,
    parameter int SIGNED      = 0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       data_in,
    input  logic                   data_valid,
    input  logic                   go,
    input  logic                   finish,
    output logic [WIDTH-1:0]       max_out,
    output logic [WIDTH-1:0]       min_out,
    output logic [WIDTH:0]         range_out,
    output logic [COUNT_WIDTH-1:0] count_out,
    output logic                   done,
`ifdef RANGE_STATS_SUM_EN
    output logic [WIDTH+COUNT_WIDTH-1:0] sum_out,
`endif
    output logic                   busy,
    output logic                   error
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_ERROR  = 2'd2;
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

    logic [1:0]             r_state;
    logic                   r_go_d;
    logic [WIDTH-1:0]       r_run_min, r_run_max;
    logic [COUNT_WIDTH-1:0] r_run_cnt;
    logic [WIDTH-1:0]       r_max_out, r_min_out;
    logic [WIDTH:0]         r_range_out;
    logic [COUNT_WIDTH-1:0] r_count_out;
    logic                   r_done, r_busy, r_error;

    // One extra bit keeps signed and unsigned compares/subtraction in one form.
    function automatic logic signed [WIDTH:0] ext(input logic [WIDTH-1:0] v);
        return (SIGNED != 0) ? {v[WIDTH-1], v} : {1'b0, v};
    endfunction

    logic                   w_go_rise, w_full;
    logic                   w_start, w_idle_err, w_active, w_take, w_fault, w_commit, w_accum;
    logic [WIDTH-1:0]       w_new_min, w_new_max, w_res_min, w_res_max;
    logic [COUNT_WIDTH-1:0] w_cnt_inc, w_res_cnt;
    logic [WIDTH:0]         w_range;

    assign w_go_rise  = go & ~r_go_d;
    assign w_full     = (r_run_cnt == CNT_MAX);
    assign w_active   = (r_state == S_ACTIVE);
    assign w_start    = ((r_state == S_IDLE) || (r_state == S_ERROR)) && go && !finish;
    assign w_idle_err = (r_state == S_IDLE) && finish;
    // While go is still held from the start cycle, non-finish samples are not taken.
    assign w_take     = w_active && !w_go_rise && data_valid && (finish || !go);
    assign w_fault    = w_active && (w_go_rise || (w_take && w_full));
    assign w_commit   = w_active && !w_fault && finish;
    assign w_accum    = w_take && !w_fault && !finish;

    assign w_new_min = (ext(data_in) < ext(r_run_min)) ? data_in : r_run_min;
    assign w_new_max = (ext(data_in) > ext(r_run_max)) ? data_in : r_run_max;
    assign w_cnt_inc = r_run_cnt + COUNT_WIDTH'(1);
    assign w_res_min = data_valid ? w_new_min : r_run_min;
    assign w_res_max = data_valid ? w_new_max : r_run_max;
    assign w_res_cnt = data_valid ? w_cnt_inc : r_run_cnt;
    assign w_range   = ext(w_res_max) - ext(w_res_min);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_go_d      <= 1'b0;
            r_run_min   <= '0;
            r_run_max   <= '0;
            r_run_cnt   <= '0;
            r_max_out   <= '0;
            r_min_out   <= '0;
            r_range_out <= '0;
            r_count_out <= '0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_go_d <= go;
            r_done <= w_commit;
            if (w_start) begin
                r_state   <= S_ACTIVE;
                r_busy    <= 1'b1;
                r_error   <= 1'b0;
                r_run_min <= data_in;
                r_run_max <= data_in;
                r_run_cnt <= COUNT_WIDTH'(1);
            end else if (w_idle_err || w_fault) begin
                r_state <= S_ERROR;
                r_busy  <= 1'b0;
                r_error <= 1'b1;
            end else if (w_commit) begin
                r_state     <= S_IDLE;
                r_busy      <= 1'b0;
                r_max_out   <= w_res_max;
                r_min_out   <= w_res_min;
                r_range_out <= w_range;
                r_count_out <= w_res_cnt;
            end else if (w_accum) begin
                r_run_min <= w_new_min;
                r_run_max <= w_new_max;
                r_run_cnt <= w_cnt_inc;
            end else if (r_state == 2'd3) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
            end
        end
    end

`ifdef RANGE_STATS_SUM_EN
    localparam int SW = WIDTH + COUNT_WIDTH;
    logic [SW-1:0] r_run_sum, r_sum_out, w_ext_data;

    assign w_ext_data = (SIGNED != 0) ? {{COUNT_WIDTH{data_in[WIDTH-1]}}, data_in}
                                      : {{COUNT_WIDTH{1'b0}}, data_in};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_run_sum <= '0;
            r_sum_out <= '0;
        end else begin
            if (w_start) begin
                r_run_sum <= w_ext_data;
            end else if (w_accum) begin
                r_run_sum <= r_run_sum + w_ext_data;
            end
            if (w_commit) begin
                r_sum_out <= data_valid ? (r_run_sum + w_ext_data) : r_run_sum;
            end
        end
    end

    assign sum_out = r_sum_out;
`endif

    assign max_out   = r_max_out;
    assign min_out   = r_min_out;
    assign range_out = r_range_out;
    assign count_out = r_count_out;
    assign done      = r_done;
    assign busy      = r_busy;
    assign error     = r_error;

endmodule

// File: tb/tb_range_stats_unit.sv
// Bench for range_stats_unit: unsigned 8-bit/8-bit-count and signed 8-bit/2-bit-count
// instances share one stimulus stream; each has its own reference model and queue.
module tb_range_stats_unit;
  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       data_valid, go, finish;

  logic [7:0] max_a, min_a, cnt_a;
  logic [8:0] rng_a;
  logic       done_a, busy_a, err_a;
  logic [7:0] max_b, min_b;
  logic [8:0] rng_b;
  logic [1:0] cnt_b;
  logic       done_b, busy_b, err_b;
`ifdef RANGE_STATS_SUM_EN
  logic [15:0] sum_a;
  logic [9:0]  sum_b;
`endif

  range_stats_unit #(.WIDTH(8), .COUNT_WIDTH(8), .SIGNED(0)) u_dut_a (
    .clock(clock), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .go(go), .finish(finish), .max_out(max_a), .min_out(min_a), .range_out(rng_a),
    .count_out(cnt_a), .done(done_a),
`ifdef RANGE_STATS_SUM_EN
    .sum_out(sum_a),
`endif
    .busy(busy_a), .error(err_a)
  );

  range_stats_unit #(.WIDTH(8), .COUNT_WIDTH(2), .SIGNED(1)) u_dut_b (
    .clock(clock), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .go(go), .finish(finish), .max_out(max_b), .min_out(min_b), .range_out(rng_b),
    .count_out(cnt_b), .done(done_b),
`ifdef RANGE_STATS_SUM_EN
    .sum_out(sum_b),
`endif
    .busy(busy_b), .error(err_b)
  );

  // clock / reset
  always #5 clock = ~clock;

  typedef struct {
    logic [7:0]  mx;
    logic [7:0]  mn;
    logic [8:0]  rg;
    logic [7:0]  cnt;
    logic [15:0] sum;
  } res_t;

  res_t qa[$];
  res_t qb[$];
  res_t cur_a, cur_b;

  // reference model: mode 0 idle, 1 collecting, 2 error; samples kept as a plain list
  int  mode[2];
  bit  merr[2];
  int  samp[2][64];
  int  ns[2];
  bit  exp_done[2];
  bit  prev_go;
  bit  mon_en = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add_sample(input int k, input int v);
    if (ns[k] < 64) samp[k][ns[k]] = v;
    ns[k]++;
  endtask

  task automatic to_error(input int k);
    mode[k] = 2;
    merr[k] = 1'b1;
  endtask

  task automatic finish_seq(input int k);
    res_t r;
    int mx, mn, tot;
    mx = samp[k][0];
    mn = samp[k][0];
    tot = 0;
    for (int i = 0; i < ns[k]; i++) begin
      if (samp[k][i] > mx) mx = samp[k][i];
      if (samp[k][i] < mn) mn = samp[k][i];
      tot += samp[k][i];
    end
    r.mx  = 8'(mx);
    r.mn  = 8'(mn);
    r.rg  = 9'(mx - mn);
    r.cnt = 8'(ns[k]);
    r.sum = 16'(tot);
    if (k == 0) qa.push_back(r);
    else qb.push_back(r);
    exp_done[k] = 1'b1;
    mode[k] = 0;
  endtask

  task automatic model_step(input int k, input int cap, input bit sgn,
                            input bit g, input bit f, input bit v, input logic [7:0] d);
    int val;
    val = sgn ? int'($signed(d)) : int'(d);
    exp_done[k] = 1'b0;
    if (mode[k] == 1) begin
      if (g && !prev_go) to_error(k);
      else if (f) begin
        if (v && ns[k] == cap) to_error(k);
        else begin
          if (v) add_sample(k, val);
          finish_seq(k);
        end
      end else if (v && !g) begin
        if (ns[k] == cap) to_error(k);
        else add_sample(k, val);
      end
    end else begin
      if (g && !f) begin
        ns[k] = 0;
        add_sample(k, val);
        mode[k] = 1;
        merr[k] = 1'b0;
      end else if (mode[k] == 0 && f) begin
        to_error(k);
      end
    end
  endtask

  // driver
  task automatic step(input bit g, input bit f, input bit v, input logic [7:0] d);
    go = g; finish = f; data_valid = v; data_in = d;
    @(posedge clock);
    model_step(0, 255, 1'b0, g, f, v, d);
    model_step(1, 3, 1'b1, g, f, v, d);
    prev_go = g;
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_max_a"}, max_a, 0);   chk({tag, "_min_a"}, min_a, 0);
    chk({tag, "_rng_a"}, rng_a, 0);   chk({tag, "_cnt_a"}, cnt_a, 0);
    chk({tag, "_ctl_a"}, {done_a, busy_a, err_a}, 0);
    chk({tag, "_max_b"}, max_b, 0);   chk({tag, "_min_b"}, min_b, 0);
    chk({tag, "_rng_b"}, rng_b, 0);   chk({tag, "_cnt_b"}, cnt_b, 0);
    chk({tag, "_ctl_b"}, {done_b, busy_b, err_b}, 0);
`ifdef RANGE_STATS_SUM_EN
    chk({tag, "_sum_a"}, sum_a, 0);   chk({tag, "_sum_b"}, sum_b, 0);
`endif
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mode[k] = 0; merr[k] = 1'b0; ns[k] = 0; exp_done[k] = 1'b0;
    end
    qa.delete();
    qb.delete();
    cur_a = '{default: '0};
    cur_b = '{default: '0};
    prev_go = 1'b0;
  endtask

  // asynchronous reset pulse placed between clock edges
  task automatic do_reset();
    #2 reset = 1'b1;
    #1 check_all_zero("async_rst");
    model_reset();
    #1 reset = 1'b0;
  endtask

  // monitor / scoreboard
  initial begin
    forever begin
      @(negedge clock);
      if (mon_en && !reset) begin
        chk("done_a", done_a, exp_done[0]);
        chk("done_b", done_b, exp_done[1]);
        if (done_a) begin
          if (qa.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_done_a: got done with empty queue at %0t", $time);
          end else cur_a = qa.pop_front();
        end
        if (done_b) begin
          if (qb.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_done_b: got done with empty queue at %0t", $time);
          end else cur_b = qb.pop_front();
        end
        chk("max_a", max_a, cur_a.mx);     chk("min_a", min_a, cur_a.mn);
        chk("range_a", rng_a, cur_a.rg);   chk("count_a", cnt_a, cur_a.cnt);
        chk("max_b", max_b, cur_b.mx);     chk("min_b", min_b, cur_b.mn);
        chk("range_b", rng_b, cur_b.rg);   chk("count_b", cnt_b, cur_b.cnt[1:0]);
`ifdef RANGE_STATS_SUM_EN
        chk("sum_a", sum_a, cur_a.sum);    chk("sum_b", sum_b, cur_b.sum[9:0]);
`endif
        chk("busy_a", busy_a, (mode[0] == 1));
        chk("busy_b", busy_b, (mode[1] == 1));
        chk("error_a", err_a, merr[0]);
        chk("error_b", err_b, merr[1]);
      end
    end
  end

  function automatic logic [7:0] rnd_data();
    logic [7:0] edges [4];
    edges[0] = 8'h00; edges[1] = 8'hFF; edges[2] = 8'h80; edges[3] = 8'h7F;
    if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 3)];
    return 8'($urandom_range(0, 255));
  endfunction

  task automatic rand_seq();
    int kind, hold, len;
    kind = $urandom_range(0, 11);
    step(1'b1, 1'b0, 1'($urandom_range(0, 1)), rnd_data());
    hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
    repeat (hold) step(1'b1, 1'b0, 1'($urandom_range(0, 1)), rnd_data());
    len = $urandom_range(0, 6);
    for (int i = 0; i < len; i++) step(1'b0, 1'b0, ($urandom_range(0, 3) != 0), rnd_data());
    if (kind == 0) begin
      step(1'b0, 1'b0, 1'b0, 8'h00);
      step(1'b1, 1'b0, 1'b1, rnd_data());
      step(1'b0, 1'b0, 1'b0, 8'h00);
    end
    if (kind == 2) do_reset();
    step(1'b0, 1'b1, 1'($urandom_range(0, 1)), rnd_data());
    repeat ($urandom_range(0, 2)) step(1'b0, 1'b0, 1'($urandom_range(0, 1)), rnd_data());
    if (kind == 1) step(1'b0, 1'b1, 1'($urandom_range(0, 1)), rnd_data());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of stimulus");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; go = 1'b0; finish = 1'b0; data_valid = 1'b0; data_in = '0;
    model_reset();
    repeat (2) @(posedge clock);
    #1 check_all_zero("reset");
    reset = 1'b0;
    mon_en = 1'b1;

    // unsigned: 20,5,200,7,50 -> max 200 min 5 range 195 count 5 sum 282
    step(1, 0, 0, 8'd20); step(0, 0, 1, 8'd5); step(0, 0, 1, 8'd200);
    step(0, 0, 1, 8'd7);  step(0, 1, 1, 8'd50); step(0, 0, 0, 8'd0);
    // signed: -3, 100, -128
    step(1, 0, 1, 8'hFD); step(0, 0, 1, 8'd100); step(0, 1, 1, 8'h80); step(0, 0, 0, 8'd0);
    // finish in IDLE, then recovery with a single-sample sequence
    step(0, 1, 0, 8'd0); step(0, 0, 0, 8'd0); step(1, 0, 0, 8'd9); step(0, 1, 0, 8'd0);
    step(0, 0, 0, 8'd0);
    // go re-rise inside a sequence
    step(1, 0, 1, 8'd10); step(0, 0, 1, 8'd11); step(1, 0, 1, 8'd12); step(0, 0, 0, 8'd0);
    step(0, 1, 0, 8'd0);  step(0, 0, 0, 8'd0);
    // count limit on the 2-bit counter instance
    step(1, 0, 1, 8'd1); step(0, 0, 1, 8'd2); step(0, 0, 1, 8'd2); step(0, 0, 1, 8'd2);
    step(0, 1, 1, 8'd3); step(0, 0, 0, 8'd0);
    // go held after the start cycle
    step(1, 0, 1, 8'd30); step(1, 0, 1, 8'd99); step(0, 0, 1, 8'd40); step(0, 1, 0, 8'd0);
    step(0, 0, 0, 8'd0);
    // reset mid-sequence, then finish with go low
    step(1, 0, 1, 8'd4); step(0, 0, 1, 8'd5); do_reset();
    step(0, 1, 1, 8'd6); step(0, 0, 0, 8'd0);

    for (int n = 0; n < 150; n++) rand_seq();
    repeat (3) step(1'b0, 1'b0, 1'b0, 8'h00);

    chk("queue_a_drained", qa.size(), 0);
    chk("queue_b_drained", qb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
